// File: rtl/mc_pkg.sv
// Shared multicycle-datapath constants: PC source and address-select encodings,
// instruction field positions and the default reset PC.
package mc_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  typedef enum logic {
    IORD_PC     = 1'b0,
    IORD_ALUOUT = 1'b1
  } iord_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int JIDX_HI   = 25;
  localparam int JIDX_LO   = 0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode_fields.sv
// Combinational instruction slicer: register fields, opcode, jump index and
// sign-extended immediate (plain and word-scaled) straight from an IR value.
module instr_decode_fields
  import mc_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [25:0] instr_index_o,
  output logic [31:0] imm_sext_o,
  output logic [31:0] imm_sext_sl2_o
);

  logic [31:0] imm_sext_s;

  assign opcode_o       = ir_i[OPCODE_HI:OPCODE_LO];
  assign rs_o           = ir_i[RS_HI:RS_LO];
  assign rt_o           = ir_i[RT_HI:RT_LO];
  assign rd_o           = ir_i[RD_HI:RD_LO];
  assign instr_index_o  = ir_i[JIDX_HI:JIDX_LO];
  assign imm_sext_s     = sext16(ir_i[IMM_HI:IMM_LO]);
  assign imm_sext_o     = imm_sext_s;
  assign imm_sext_sl2_o = {imm_sext_s[29:0], 2'b00};

endmodule

// File: rtl/pc_ir_unit.sv
// Front half of the multicycle datapath: PC, IR, MDR and ALUOut registers,
// unified memory address mux, saturating fetch counter and sticky misalign flag.
module pc_ir_unit
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic [1:0]       PCSource,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      alu_out,
  output logic [31:0]      mdr,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      imm_sext,
  output logic [31:0]      imm_sext_sl2,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misalign_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      mdr_q, mdr_d;
  logic [31:0]      alu_out_q, alu_out_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic             misalign_q, misalign_d;

  pcsrc_e      pc_source_s;
  logic [31:0] pc_next_s;
  logic        pc_next_valid_s;
  logic        pc_we_s;
  logic        pc_upd_s;
  logic [25:0] instr_index_s;

  assign pc_source_s = pcsrc_e'(PCSource);

  instr_decode_fields u_fields (
    .ir_i           (ir_q),
    .opcode_o       (opcode),
    .rs_o           (rs),
    .rt_o           (rt),
    .rd_o           (rd),
    .instr_index_o  (instr_index_s),
    .imm_sext_o     (imm_sext),
    .imm_sext_sl2_o (imm_sext_sl2)
  );

  // PC source mux; the reserved encoding marks the candidate invalid so the PC holds.
  always_comb begin
    pc_next_s       = pc_q;
    pc_next_valid_s = 1'b0;
    case (pc_source_s)
      PCSRC_ALU: begin
        pc_next_s       = alu_result;
        pc_next_valid_s = 1'b1;
      end
      PCSRC_ALUOUT: begin
        pc_next_s       = alu_out_q;
        pc_next_valid_s = 1'b1;
      end
      PCSRC_JUMP: begin
        pc_next_s       = {pc_q[31:28], instr_index_s, 2'b00};
        pc_next_valid_s = 1'b1;
      end
      PCSRC_RSVD: begin
        pc_next_s       = pc_q;
        pc_next_valid_s = 1'b0;
      end
      default: begin
        pc_next_s       = pc_q;
        pc_next_valid_s = 1'b0;
      end
    endcase
  end

  assign pc_we_s  = PCWrite | (PCWriteCond & alu_zero);
  assign pc_upd_s = pc_we_s & pc_next_valid_s;

  // Next-state for all architectural registers.
  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = misalign_q;
    mdr_d         = mem_rdata;
    alu_out_d     = alu_result;
    if (pc_upd_s) begin
      pc_d       = pc_next_s;
      misalign_d = misalign_q | (pc_next_s[1:0] != 2'b00);
    end else begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
    end
    if (IRWrite) begin
      ir_d = mem_rdata;
      if (fetch_count_q != CNT_MAX) begin
        fetch_count_d = fetch_count_q + CNT_ONE;
      end else begin
        fetch_count_d = fetch_count_q;
      end
    end else begin
      ir_d          = ir_q;
      fetch_count_d = fetch_count_q;
    end
  end

  // State registers with synchronous reset overriding every enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ir_q          <= 32'h0000_0000;
      mdr_q         <= 32'h0000_0000;
      alu_out_q     <= 32'h0000_0000;
      fetch_count_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      mdr_q         <= mdr_d;
      alu_out_q     <= alu_out_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
    end
  end

  assign mem_addr     = (iord_e'(IorD) == IORD_ALUOUT) ? alu_out_q : pc_q;
  assign pc           = pc_q;
  assign alu_out      = alu_out_q;
  assign mdr          = mdr_q;
  assign fetch_count  = fetch_count_q;
  assign misalign_err = misalign_q;

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Sequential front half of the multicycle datapath: program counter, instruction register (IR), memory data register (MDR) and ALUOut register.
- Driven directly by the multicycle control unit's PCWrite, PCWriteCond, PCSource, IorD and IRWrite outputs.
- Feeds the control unit its opcode, and feeds the register file and ALU the decoded instruction fields.
- Also forms the unified memory address and keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the fetch counter; saturates, does not wrap.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- PCWrite  in  1  unconditional PC write enable
- PCWriteCond  in  1  PC write enable qualified by alu_zero
- PCSource  in  2  PC next-value select
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  in  1  IR load enable
- alu_result  in  32  combinational ALU output
- alu_zero  in  1  ALU zero flag
- mem_rdata  in  32  memory read data
- mem_addr  out  32  memory address
- pc  out  32  current PC register
- alu_out  out  32  ALUOut register
- mdr  out  32  MDR register
- opcode  out  6  IR[31:26], to control unit
- rs  out  5  IR[25:21]
- rt  out  5  IR[20:16]
- rd  out  5  IR[15:11]
- imm_sext  out  32  sign-extended IR[15:0]
- imm_sext_sl2  out  32  imm_sext shifted left by 2
- fetch_count  out  CNT_W  number of IR loads since reset
- misalign_err  out  1  sticky: PC was written with a value whose [1:0] != 0

Behaviour:
- Reset (rst=1 at edge):
  - pc = RESET_PC; IR, MDR and ALUOut = 0; fetch_count = 0; misalign_err = 0.
  - Reset overrides all enables, including mid-instruction.
  - Derived outputs follow from the zero IR: opcode = 0, imm_sext = 0.
- PC next-value mux (pc_next):
  - PCSource 00 = alu_result (PC+4 during fetch).
  - 01 = alu_out (branch target computed in decode).
  - 10 = {pc[31:28], IR[25:0], 2'b00} (jump).
  - 11 = reserved; PC holds even if enabled.
- PC write condition: pc_we = PCWrite | (PCWriteCond & alu_zero).
  - PCWrite and PCWriteCond both high: PCWrite dominates, PC written regardless of alu_zero.
  - When pc_we is set and PCSource != 11, pc <= pc_next at the edge.
  - The new PC is visible the following cycle.
- misalign_err is set when pc_we, PCSource != 11 and pc_next[1:0] != 0.
  - The PC is still written.
  - Cleared only by rst.
- IR: loads mem_rdata at the edge when IRWrite = 1, otherwise holds.
  - Load occurs in the control unit's FETCH cycle.
  - opcode and all fields are valid from the next cycle (DECODE) onward.
- MDR: loads mem_rdata every cycle, unconditionally.
  - The load-word data captured in the memory-access cycle is available to write-back one cycle later.
- ALUOut: loads alu_result every cycle, unconditionally.
- mem_addr: combinational, IorD ? alu_out : pc; zero added latency.
- Field outputs: purely combinational from IR.
  - imm_sext = {{16{IR[15]}}, IR[15:0]}.
  - imm_sext_sl2 = {imm_sext[29:0], 2'b00}.
- fetch_count: increments by 1 on every edge with IRWrite = 1; saturates at all-ones.
- All arithmetic is 32-bit unsigned; the PC register itself never overflows-checks (the ALU supplies PC+4).

Decomposition:
- Shared package (mc_pkg): PCSource encodings PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_RSVD = 2'b11; IorD encodings; instruction field bit positions; RESET_PC default.
- The control unit is migrated to these constants.
- One natural sub-module: instr_decode_fields (combinational IR slicer and sign-extender), reused later by the pipelined variant.
- Everything else stays flat in pc_ir_unit.

Test Plan:
- Reset: hold rst 2 cycles with all enables high → pc = RESET_PC, opcode = 0, fetch_count = 0, misalign_err = 0, mem_addr = RESET_PC.
- Fetch: pc = 0, mem_rdata = 32'h8C22_0004, IRWrite = 1, PCWrite = 1, PCSource = 00, alu_result = 4 → next cycle pc = 4, opcode = 6'b100011, rs = 1, rt = 2, imm_sext = 4, fetch_count = 1.
- Branch:
  - PCWriteCond = 1, PCSource = 01, alu_out = 32'h40, alu_zero = 1 → pc = 32'h40.
  - Repeat with alu_zero = 0 → pc unchanged.
  - PCWrite = 1 with PCWriteCond = 1 and alu_zero = 0 → pc written.
- Jump: pc = 32'hA000_0010, IR = 32'h0800_0100, PCWrite = 1, PCSource = 10 → pc = 32'hA000_0400.
- Memory path and boundaries:
  - IorD = 1, alu_out = 32'h100 → mem_addr = 32'h100 same cycle; mdr equals mem_rdata one cycle later.
  - PCSource = 11 with PCWrite → pc holds.
  - alu_result = 32'h6 written to PC → misalign_err = 1 and stays set until rst.
  - fetch_count preset near all-ones → saturates, no wrap.
